fancytimer_cmd_tx: RTL and testbench

//  Initiator side of the fancy-timer serial protocol. On request, serialises the start

---
 rtl/fancytimer_pkg.sv | 19 +
 rtl/ft_watchdog.sv | 29 ++
 rtl/fancytimer_cmd_tx.sv | 143 ++++++++++++++
 tb/tb_fancytimer_cmd_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fancytimer_pkg.sv
// Shared definitions for the fancy-timer command initiator: frame constants,
// FSM state encoding and default timing parameters.
package fancytimer_pkg;

    localparam logic [3:0] PREAMBLE                = 4'b1101;
    localparam int         PAYLOAD_BITS            = 4;
    localparam int         DEFAULT_CYCLES_PER_UNIT = 1000;
    localparam int         DEFAULT_TIMEOUT_SLACK   = 16;
    localparam int         DEFAULT_CNT_W           = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        PAY       = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } state_t;

endpackage

// File: rtl/ft_watchdog.sv
// Saturating latency counter with a limit comparison; count is 0 on the
// first enabled cycle after a clear and steps by one each enabled cycle.
module ft_watchdog
    import fancytimer_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/fancytimer_cmd_tx.sv
// Initiator for the fancy-timer serial protocol: sends 1101 plus a 4-bit delay,
// waits for done under a watchdog, then acknowledges with a one-cycle ack.
module fancytimer_cmd_tx
    import fancytimer_pkg::*;
#(
    parameter int CYCLES_PER_UNIT = DEFAULT_CYCLES_PER_UNIT,
    parameter int TIMEOUT_SLACK   = DEFAULT_TIMEOUT_SLACK,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       delay,
    output logic             busy,
    output logic             data,
    input  logic             done,
    output logic             ack,
    output logic             complete,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);

    state_t           state, state_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       sh, sh_d;
    logic [3:0]       delay_q, delay_d;
    logic             data_d, ack_d, complete_d, timeout_d;
    logic [CNT_W-1:0] cycles_d;

    logic [CNT_W-1:0] wd_count;
    logic [CNT_W-1:0] wd_limit;
    logic             wd_expired;

    // (delay+1)*CYCLES_PER_UNIT + TIMEOUT_SLACK, evaluated modulo 2**CNT_W.
    assign wd_limit = ({{(CNT_W-4){1'b0}}, delay_q} + CNT_W'(1)) * CNT_W'(CYCLES_PER_UNIT)
                      + CNT_W'(TIMEOUT_SLACK);

    ft_watchdog #(
        .CNT_W(CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != WAIT_DONE),
        .enable (state == WAIT_DONE),
        .limit  (wd_limit),
        .count  (wd_count),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            sh       <= '0;
            delay_q  <= '0;
            data     <= 1'b0;
            ack      <= 1'b0;
            complete <= 1'b0;
            timeout  <= 1'b0;
            cycles   <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            sh       <= sh_d;
            delay_q  <= delay_d;
            data     <= data_d;
            ack      <= ack_d;
            complete <= complete_d;
            timeout  <= timeout_d;
            cycles   <= cycles_d;
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        sh_d       = sh;
        delay_d    = delay_q;
        data_d     = 1'b0;
        ack_d      = 1'b0;
        complete_d = 1'b0;
        timeout_d  = 1'b0;
        cycles_d   = cycles;

        case (state)
            IDLE: begin
                if (start) begin
                    delay_d = delay;
                    sh_d    = {PREAMBLE, delay};
                    data_d  = PREAMBLE[3];
                    idx_d   = '0;
                    state_d = PRE;
                end
            end

            // data already shows sh[7]; each edge presents the next bit from sh[6].
            PRE: begin
                data_d = sh[6];
                sh_d   = {sh[6:0], 1'b0};
                idx_d  = idx + 3'd1;
                if (idx == 3'(PAYLOAD_BITS - 1)) begin
                    state_d = PAY;
                end
            end

            PAY: begin
                if (idx == 3'd7) begin
                    data_d  = 1'b0;
                    idx_d   = '0;
                    state_d = WAIT_DONE;
                end else begin
                    data_d = sh[6];
                    sh_d   = {sh[6:0], 1'b0};
                    idx_d  = idx + 3'd1;
                end
            end

            // done takes priority over an expiring watchdog in the same cycle.
            WAIT_DONE: begin
                if (done) begin
                    cycles_d   = wd_count;
                    ack_d      = 1'b1;
                    complete_d = 1'b1;
                    state_d    = ACK;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fancytimer_cmd_tx.sv
// Directed bench for fancytimer_cmd_tx: frame bits, done latency capture,
// watchdog timeout, start filtering, reset abort and back-to-back commands.
module tb_fancytimer_cmd_tx;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  delay;
    logic        busy;
    logic        data;
    logic        done;
    logic        ack;
    logic        complete;
    logic        timeout;
    logic [14:0] cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fancytimer_cmd_tx dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .delay   (delay),
        .busy    (busy),
        .data    (data),
        .done    (done),
        .ack     (ack),
        .complete(complete),
        .timeout (timeout),
        .cycles  (cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one command starting in the current cycle. end_cyc is the last
    // WAIT_DONE cycle: done is raised there when use_done is set, otherwise
    // the timeout pulse is expected in the cycle after it.
    task automatic run_cmd(input logic [3:0] d, input int end_cyc, input bit use_done,
                           input logic [14:0] exp_cycles, input bit start_in_ack);
        logic [7:0] frame;
        bit         bad;
        frame = {4'b1101, d};
        bad   = 1'b0;
        start = 1'b1;
        delay = d;
        cyc   = 0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("frame_bit", data, frame[7-k]);
            chk("frame_busy", busy, 1);
            tick();
        end
        chk("post_frame_data", data, 0);
        while (cyc < end_cyc) begin
            if (ack || complete || timeout || data || !busy) bad = 1'b1;
            tick();
        end
        if (ack || complete || timeout || data || !busy) bad = 1'b1;
        chk("wait_quiet", bad, 0);
        if (use_done) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("ack_pulse", ack, 1);
            chk("complete_pulse", complete, 1);
            chk("ack_no_timeout", timeout, 0);
            chk("ack_busy", busy, 1);
            chk("ack_data", data, 0);
            chk("cycles_capture", cycles, exp_cycles);
            if (start_in_ack) start = 1'b1;
            tick();
            start = 1'b0;
            chk("ack_drop", ack, 0);
            chk("complete_drop", complete, 0);
            chk("idle_busy", busy, 0);
            chk("idle_data", data, 0);
            chk("cycles_hold", cycles, exp_cycles);
            if (start_in_ack) begin
                tick();
                chk("ack_start_ignored_busy", busy, 0);
                chk("ack_start_ignored_data", data, 0);
            end
        end else begin
            tick();
            chk("timeout_pulse", timeout, 1);
            chk("timeout_busy", busy, 0);
            chk("timeout_no_ack", ack, 0);
            chk("timeout_no_complete", complete, 0);
            chk("timeout_cycles_kept", cycles, exp_cycles);
            tick();
            chk("timeout_drop", timeout, 0);
        end
    endtask

    initial begin
        bit bad;
        reset = 1'b1;
        start = 1'b0;
        delay = 4'd0;
        done  = 1'b0;
        tick();
        tick();
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_complete", complete, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycles, 0);
        reset = 1'b0;
        tick();

        // delay=0, done raised in cycle 1009 -> ack in 1010, cycles=1000
        run_cmd(4'd0, 1009, 1'b1, 15'd1000, 1'b0);

        // done in IDLE is ignored
        done = 1'b1;
        tick();
        tick();
        chk("idle_done_no_ack", ack, 0);
        chk("idle_done_no_busy", busy, 0);
        done = 1'b0;
        tick();

        // delay=15, done after 16000 counting cycles
        run_cmd(4'd15, 16009, 1'b1, 15'd16000, 1'b0);
        // delay=15, no done: counter reaches 16016 in cycle 16025
        run_cmd(4'd15, 16025, 1'b0, 15'd16000, 1'b0);
        // delay=0 boundary: counter hits limit 1016 in cycle 1025 together with done
        run_cmd(4'd0, 1025, 1'b1, 15'd1016, 1'b0);

        // start held 40 cycles with delay=5; delay changed mid-frame
        start = 1'b1;
        delay = 4'd5;
        cyc   = 0;
        tick();
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] fr;
            fr = 8'b1101_0101;
            if (k == 2) delay = 4'd9;
            chk("held_frame_bit", data, fr[7-k]);
            tick();
        end
        while (cyc < 40) begin
            if (data || ack || !busy) bad = 1'b1;
            tick();
        end
        start = 1'b0;
        chk("held_single_frame", bad, 0);
        while (cyc < 50) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("held_ack", ack, 1);
        chk("held_cycles", cycles, 41);
        tick();
        chk("held_idle", busy, 0);
        tick();
        chk("held_no_requeue", busy, 0);
        chk("held_no_requeue_data", data, 0);

        // reset on cycle 5 of a frame aborts it
        start = 1'b1;
        delay = 4'd2;
        cyc   = 0;
        tick();
        start = 1'b0;
        while (cyc < 5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_data", data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cycles", cycles, 0);
        tick();
        run_cmd(4'd7, 20, 1'b1, 15'd11, 1'b0);

        // start pulsed only in the ACK cycle is dropped
        run_cmd(4'd4, 30, 1'b1, 15'd21, 1'b1);

        // back-to-back, then delay=3 and delay=1 latencies
        run_cmd(4'd3, 4009, 1'b1, 15'd4000, 1'b0);
        run_cmd(4'd1, 2009, 1'b1, 15'd2000, 1'b0);
        run_cmd(4'd10, 12, 1'b1, 15'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
